// File: rtl/apb_request_scheduler.sv
// ---------------------------------------------------------------------------
// apb_request_scheduler
//   Shares one APB master port between N_REQ internal requesters. Requesters
//   are arbitrated round-robin, the winner's address is decoded to a one-hot
//   PSEL, and the APB SETUP/ACCESS phases are driven. A per-transfer ACCESS
//   timeout guarantees forward progress if no slave ever raises PREADY.
//
// Ports
//   i_PCLK, i_PRESET        clock, asynchronous active-high reset
//   i_req/_write/_addr/_wdata  per-requester request, fields packed by index
//   o_req_ack               one-cycle completion pulse to the owner
//   o_rsp_data/o_rsp_error  response, valid while o_req_ack is nonzero
//   o_grant, o_busy         current owner (one-hot), non-idle flag
//   o_PSEL..o_PWDATA        APB request toward the slaves
//   i_PREADY/PRDATA/PSLVERR merged slave response
// ---------------------------------------------------------------------------
module apb_request_scheduler #(
    parameter int SEL_WIDTH      = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        i_PCLK,
    input  logic                        i_PRESET,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [N_REQ-1:0]            o_req_ack,
    output logic [DATA_WIDTH-1:0]       o_rsp_data,
    output logic                        o_rsp_error,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_busy,
    output logic [SEL_WIDTH-1:0]        o_PSEL,
    output logic                        o_PENABLE,
    output logic                        o_PWRITE,
    output logic [ADDR_WIDTH-1:0]       o_PADDR,
    output logic [DATA_WIDTH-1:0]       o_PWDATA,
    input  logic                        i_PREADY,
    input  logic [DATA_WIDTH-1:0]       i_PRDATA,
    input  logic                        i_PSLVERR
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          last_q, last_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

    // Round-robin pick: first requester found searching upward from last+1.
    logic                   arb_found;
    logic [IW-1:0]          arb_idx;
    logic [IW:0]            arb_sum;
    logic [ADDR_WIDTH-1:0]  arb_addr;
    logic                   arb_write;
    logic [DATA_WIDTH-1:0]  arb_wdata;
    logic [1:0]             arb_dec;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            arb_sum = {1'b0, last_q} + (IW+1)'(i);
            if (arb_sum >= (IW+1)'(N_REQ))
                arb_sum = arb_sum - (IW+1)'(N_REQ);
            if (!arb_found && i_req[arb_sum[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        arb_addr  = '0;
        arb_write = 1'b0;
        arb_wdata = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_idx == IW'(j)) begin
                arb_addr  = i_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                arb_write = i_req_write[j];
                arb_wdata = i_req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        arb_dec = arb_addr[ADDR_WIDTH-1 -: 2];
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    gidx_d           = arb_idx;
                    addr_d           = arb_addr;
                    write_d          = arb_write;
                    wdata_d          = arb_wdata;
                    cnt_d            = '0;
                    if (arb_dec == 2'd3) begin
                        // Unmapped region: complete with an error, no bus cycle.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        sel_d   = SEL_WIDTH'(1) << arb_dec;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (i_PREADY) begin
                    rdata_d = write_q ? '0 : i_PRDATA;
                    err_d   = i_PSLVERR;
                    state_d = S_RESP;
                end else if (cnt_q == TW'(TIMEOUT_CYCLES-1)) begin
                    // Slave never answered: abort with an error.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                last_d  = gidx_q;
                cnt_d   = '0;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(N_REQ-1);
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from registered state, so an asynchronous reset
    // clears them immediately.
    logic in_bus, in_resp;
    assign in_bus  = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign in_resp = (state_q == S_RESP);

    assign o_PSEL      = in_bus ? sel_q : '0;
    assign o_PENABLE   = (state_q == S_ACCESS);
    assign o_PWRITE    = write_q;
    assign o_PADDR     = addr_q;
    assign o_PWDATA    = wdata_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_req_ack   = in_resp ? grant_q : '0;
    assign o_rsp_data  = in_resp ? rdata_q : '0;
    assign o_rsp_error = in_resp ? err_q : 1'b0;

endmodule

// File: tb/tb_apb_request_scheduler.sv
module tb_apb_request_scheduler;

    localparam int N = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      i_req = '0;
    logic [N-1:0]      i_req_write = '0;
    logic [N*AW-1:0]   i_req_addr = '0;
    logic [N*DW-1:0]   i_req_wdata = '0;
    logic [N-1:0]      o_req_ack;
    logic [DW-1:0]     o_rsp_data;
    logic              o_rsp_error;
    logic [N-1:0]      o_grant;
    logic              o_busy;
    logic [2:0]        o_PSEL;
    logic              o_PENABLE;
    logic              o_PWRITE;
    logic [AW-1:0]     o_PADDR;
    logic [DW-1:0]     o_PWDATA;
    logic              i_PREADY = 1'b0;
    logic [DW-1:0]     i_PRDATA = '0;
    logic              i_PSLVERR = 1'b0;

    apb_request_scheduler #(
        .SEL_WIDTH(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_PCLK(clk), .i_PRESET(rst),
        .i_req(i_req), .i_req_write(i_req_write), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .o_req_ack(o_req_ack), .o_rsp_data(o_rsp_data),
        .o_rsp_error(o_rsp_error), .o_grant(o_grant), .o_busy(o_busy),
        .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
        .o_PADDR(o_PADDR), .o_PWDATA(o_PWDATA), .i_PREADY(i_PREADY),
        .i_PRDATA(i_PRDATA), .i_PSLVERR(i_PSLVERR)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [N-1:0] ack, input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.ack = ack; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // Slave model: PREADY after wait_n low ACCESS cycles, never if hang.
    int          wait_n = 0;
    bit          hang = 0;
    logic [31:0] slv_data = '0;
    logic        slv_err = 1'b0;
    int          acc = 0;

    always @(negedge clk) begin
        if (o_PENABLE) begin
            i_PREADY = !hang && (acc >= wait_n);
            acc++;
        end else begin
            i_PREADY = 1'b0;
            acc = 0;
        end
        i_PRDATA  = slv_data;
        i_PSLVERR = slv_err;
    end

    // Monitor: every ack is matched against the next scoreboard entry.
    always @(negedge clk) begin
        if (o_req_ack != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%b required=none", o_req_ack);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_vec", 64'(o_req_ack), 64'(mon_e.ack));
                chk("rsp_data", 64'(o_rsp_data), 64'(mon_e.data));
                chk("rsp_err", 64'(o_rsp_error), 64'(mon_e.err));
            end
        end
    end

    // Per-transfer observations gathered by run_xfer
    int         lat, pen_cnt, bus_bad;
    logic [2:0] sel_c1;
    logic       en_c1, en_c2;

    task automatic run_xfer(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] sel_exp);
        bit got;
        @(negedge clk);
        i_req_write[k]         = wr;
        i_req_addr[k*AW +: AW]  = addr;
        i_req_wdata[k*DW +: DW] = wdata;
        i_req[k]               = 1'b1;
        lat = 0; pen_cnt = 0; bus_bad = 0; got = 0;
        sel_c1 = '0; en_c1 = 1'b0; en_c2 = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin sel_c1 = o_PSEL; en_c1 = o_PENABLE; end
            if (lat == 2) en_c2 = o_PENABLE;
            if (o_PENABLE) pen_cnt++;
            if (o_PSEL != '0) begin
                if (o_PSEL != sel_exp || o_PADDR != addr || o_PWRITE != wr ||
                    (wr && o_PWDATA != wdata))
                    bus_bad++;
            end
            if (o_req_ack[k]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_wait req%0d actual=no_ack required=ack", k);
        end
        i_req[k] = 1'b0;
    endtask

    initial begin
        int ack_cyc[4];
        int nacks;
        int cyc;
        bit got;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_zero", 64'(|{o_req_ack, o_rsp_data, o_rsp_error, o_grant, o_busy,
                                     o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA}), 64'd0);
        rst = 1'b0;

        // Round-robin: all three hold requests from reset
        wait_n = 0; hang = 0; slv_data = 32'hA5A5_0001; slv_err = 1'b0;
        push(3'b001, 32'hA5A5_0001, 1'b0);
        push(3'b010, 32'hA5A5_0001, 1'b0);
        push(3'b100, 32'hA5A5_0001, 1'b0);
        push(3'b001, 32'hA5A5_0001, 1'b0);
        for (int i = 0; i < N; i++) begin
            i_req_addr[i*AW +: AW] = 32'h4000_0000;
            i_req_write[i] = 1'b0;
        end
        i_req = 3'b111;
        nacks = 0; cyc = 0;
        while (nacks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (o_req_ack != '0) begin ack_cyc[nacks] = cyc; nacks++; end
        end
        i_req = '0;
        chk("rr_ack_count", 64'(nacks), 64'd4);
        chk("rr_first_lat", 64'(ack_cyc[0]), 64'd3);
        for (int i = 1; i < 4; i++)
            chk("rr_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd4);

        // Single read, zero wait states
        slv_data = 32'hDEAD_BEEF;
        push(3'b001, 32'hDEAD_BEEF, 1'b0);
        run_xfer(0, 1'b0, 32'h0000_0010, 32'h0, 3'b001);
        chk("rd_c1_psel", 64'(sel_c1), 64'b001);
        chk("rd_c1_penable", 64'(en_c1), 64'd0);
        chk("rd_c2_penable", 64'(en_c2), 64'd1);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_bus", 64'(bus_bad), 64'd0);

        // Write with 5 wait states and slave error; data must read back 0
        wait_n = 5; slv_data = 32'hFFFF_FFFF; slv_err = 1'b1;
        push(3'b010, 32'h0, 1'b1);
        run_xfer(1, 1'b1, 32'h8000_0004, 32'h1234_5678, 3'b100);
        chk("ws_latency", 64'(lat), 64'd8);
        chk("ws_penable_cycles", 64'(pen_cnt), 64'd6);
        chk("ws_bus_stable", 64'(bus_bad), 64'd0);
        chk("ws_c1_psel", 64'(sel_c1), 64'b100);

        // Timeout with PREADY stuck low
        wait_n = 0; slv_err = 1'b0; hang = 1;
        push(3'b100, 32'h0, 1'b1);
        run_xfer(2, 1'b0, 32'h0000_0100, 32'h0, 3'b001);
        chk("to_penable_cycles", 64'(pen_cnt), 64'd16);
        chk("to_latency", 64'(lat), 64'd18);
        chk("to_psel_ack", 64'(o_PSEL), 64'd0);
        chk("to_bus", 64'(bus_bad), 64'd0);
        hang = 0;

        // Unmapped address: no bus activity at all
        push(3'b001, 32'h0, 1'b1);
        run_xfer(0, 1'b0, 32'hC000_0000, 32'h0, 3'b000);
        chk("um_latency", 64'(lat), 64'd1);
        chk("um_psel_quiet", 64'(bus_bad), 64'd0);
        chk("um_penable", 64'(pen_cnt), 64'd0);

        // Reset in ACCESS: outputs clear at once, no ack for the aborted transfer
        hang = 1;
        @(negedge clk);
        i_req_addr[0 +: AW] = 32'h0000_0000;
        i_req_write[0] = 1'b0;
        i_req[0] = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (o_PENABLE) got = 1;
        end
        chk("rst_reached_access", 64'(got), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_zero", 64'(|{o_req_ack, o_rsp_data, o_rsp_error, o_grant, o_busy,
                                    o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA}), 64'd0);
        i_req = '0;
        hang = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Pointer is back at its reset value, so 1 beats 2
        slv_data = 32'h0000_0111;
        push(3'b010, 32'h0000_0111, 1'b0);
        push(3'b100, 32'h0000_0111, 1'b0);
        i_req_addr[1*AW +: AW] = 32'h0000_0020;
        i_req_addr[2*AW +: AW] = 32'h4000_0020;
        i_req_write[1] = 1'b0;
        i_req_write[2] = 1'b0;
        i_req[1] = 1'b1;
        i_req[2] = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", 64'(o_grant), 64'b010);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (o_req_ack[1]) got = 1;
            else @(negedge clk);
        end
        chk("post_rst_ack1", 64'(got), 64'd1);
        i_req[1] = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (o_req_ack[2]) got = 1;
        end
        chk("post_rst_ack2", 64'(got), 64'd1);
        i_req[2] = 1'b0;

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_request_scheduler.md
# apb_request_scheduler

APB master-side scheduler that shares one APB bus between `N_REQ` internal requesters. It accepts simple request/acknowledge transactions from each requester and arbitrates among them with round-robin priority. It decodes the target slave from the address, drives the APB SETUP/ACCESS phases toward the three execution-unit slaves, and returns read data and error status from the response path (the merged slave response produced by `apb_arbiter`). A per-transfer timeout guarantees forward progress if a slave never asserts PREADY.

## Interface
- `SEL_WIDTH`, 3: one-hot PSEL width, one bit per slave.
- `ADDR_WIDTH`, 32: APB address width.
- `DATA_WIDTH`, 32: APB data width.
- `N_REQ`, 3: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles before a transfer is aborted (≥2).

Ports:
- `i_PCLK`  in  1  bus clock; all state updates on its rising edge.
- `i_PRESET`  in  1  reset, asynchronous, active-high.
- `i_req`  in  N_REQ  per-requester request; held high with stable fields until the matching `o_req_ack`.
- `i_req_write`  in  N_REQ  1 = write, 0 = read.
- `i_req_addr`  in  N_REQ*ADDR_WIDTH  flattened addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `i_req_wdata`  in  N_REQ*DATA_WIDTH  flattened write data, same packing.
- `o_req_ack`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `o_rsp_data`  out  DATA_WIDTH  read data; valid while `o_req_ack` is nonzero.
- `o_rsp_error`  out  1  error flag; valid while `o_req_ack` is nonzero.
- `o_grant`  out  N_REQ  one-hot owner of the current transfer; 0 when idle.
- `o_busy`  out  1  high in every state except IDLE.
- `o_PSEL`  out  SEL_WIDTH  one-hot slave select.
- `o_PENABLE`  out  1  APB enable.
- `o_PWRITE`  out  1  APB direction.
- `o_PADDR`  out  ADDR_WIDTH  APB address.
- `o_PWDATA`  out  DATA_WIDTH  APB write data.
- `i_PREADY`  in  1  merged slave ready.
- `i_PRDATA`  in  DATA_WIDTH  merged slave read data.
- `i_PSLVERR`  in  1  merged slave error.

## Operation
- **Reset.** All outputs are 0 and the state is IDLE. The round-robin pointer is set to `last=N_REQ-1`, so requester 0 has the highest priority first. The timeout counter is 0.
- **States.**
  - **IDLE.** If any `i_req` bit is high, the scheduler grants the first requesting index searching from `last+1` upward, with wrap-around. It latches that requester's addr, write flag and wdata, and sets `o_grant`.
    - Decode uses `addr[ADDR_WIDTH-1 -: 2]`: 0 selects PSEL 3'b001, 1 selects 3'b010, 2 selects 3'b100.
    - A decoded value of 3 is unmapped. The transfer goes straight to RESP with `o_rsp_error=1` and `o_rsp_data=0`, and no bus activity occurs.
    - Mapped addresses go to SETUP.
  - **SETUP.** `o_PSEL` is set to the decoded value and `o_PENABLE=0`. PADDR, PWRITE and PWDATA are driven from the latched values. The next state is always ACCESS.
  - **ACCESS.** `o_PENABLE=1`; PSEL and all other bus outputs are held.
    - If `i_PREADY=1`: capture `i_PRDATA` for reads (0 for writes) and capture `i_PSLVERR`, then go to RESP.
    - Otherwise the timeout counter increments. When it reaches `TIMEOUT_CYCLES-1` with PREADY still low, go to RESP with `o_rsp_error=1` and `o_rsp_data=0`.
  - **RESP.** `o_PSEL=0` and `o_PENABLE=0`. `o_req_ack[grant]=1` for exactly this cycle, with the response fields valid. `last` is updated to the granted index and the counter is cleared. The next state is IDLE and `o_grant` clears on entry to IDLE.
- **Requester rules.**
  - A requester whose `i_req` is still high in the IDLE cycle after its ack is treated as issuing a new request and competes under round-robin.
  - Dropping `i_req` mid-transfer is a protocol violation. The scheduler still completes the latched transfer and pulses the ack.
- **Bus output behaviour.** PADDR, PWRITE and PWDATA hold their last values when PSEL=0; no value is specified for them in that case. PSEL stays one-hot or zero at all times.
- **Reset during a transfer.** Asserting `i_PRESET` in any state immediately forces all outputs to 0 and the state to IDLE. No ack is issued for the aborted transfer, and the pointer returns to its reset value.

## Timing
- For a mapped transfer with a request first sampled in IDLE at edge 0:
  - SETUP occupies cycle 1.
  - ACCESS occupies cycle 2.
  - With zero wait states, the ack is in cycle 3.
- Each PREADY-low cycle adds one cycle.
- An unmapped address is acked in cycle 1.
- Minimum spacing between back-to-back transfers is 4 cycles, because an IDLE cycle always separates RESP from the next SETUP.
- Timeout: the ack comes at most `TIMEOUT_CYCLES+2` cycles after the grant.
- `i_PRDATA` and `i_PSLVERR` are sampled only on the ACCESS edge where `i_PREADY=1`.

## Test plan
- **Single read.** Requester 0 reads 0x0000_0010; slave returns PREADY=1 immediately with PRDATA 0xDEADBEEF.
  - Cycle 1: PSEL=001, PENABLE=0.
  - Cycle 2: PENABLE=1.
  - Cycle 3: `o_req_ack`=001, `o_rsp_data`=0xDEADBEEF, `o_rsp_error`=0.
- **Round-robin.** All three requesters hold requests from reset, each targeting 0x4000_0000, with 0-wait slaves. Acks arrive in order 0,1,2,0, spaced 4 cycles apart.
- **Wait states and slave error.** A write to 0x8000_0004 with data 0x1234_5678, with PREADY low for 5 ACCESS cycles and then PREADY=1 with PSLVERR=1.
  - PSEL=100 and PWDATA=0x1234_5678 stay stable throughout.
  - The ack comes 8 cycles after the grant with `o_rsp_error`=1 and `o_rsp_data`=0.
- **Timeout.** With TIMEOUT_CYCLES=16 and PREADY held at 0:
  - PENABLE stays high for exactly 16 cycles.
  - The ack follows with `o_rsp_error`=1.
  - PSEL returns to 0.
- **Unmapped address.** A read of 0xC000_0000:
  - PSEL stays 0 throughout.
  - The ack arrives 1 cycle after the grant with `o_rsp_error`=1 and data 0.
- **Reset mid-transfer.** Assert `i_PRESET` during ACCESS.
  - All outputs drop to 0 asynchronously and no ack is issued.
  - After release, a new simultaneous request from requesters 1 and 2 grants requester 1 first.
